// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve block: prediction kinds and the in-flight record layout.
package branch_resolve_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_BR   = 2'd1,
        KIND_JAL  = 2'd2,
        KIND_JALR = 2'd3
    } pred_kind_e;

    localparam int REC_XLEN = 32;

    // Default-width record; the resolve top re-declares the same layout at its own XLEN.
    typedef struct packed {
        logic [REC_XLEN-1:0] pc;
        logic                rvc;
        pred_kind_e          kind;
        logic                taken;
        logic [REC_XLEN-1:0] target;
    } pred_rec_t;

    function automatic int rec_bits(input int xlen);
        return 2 * xlen + 4;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Fetch/execute-facing bundle of branch_resolve: prediction push, resolution, flush and training outputs.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    import branch_resolve_pkg::*;

    logic            pred_push;
    logic [XLEN-1:0] pred_pc;
    logic            pred_rvc;
    pred_kind_e      pred_kind;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            pred_full;

    logic            res_valid;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            flush_ext;

    logic            predict_fail;
    logic [XLEN-1:0] redirect_pc;
    logic            bht_updata;
    logic [XLEN-1:0] bht_pc;
    logic            bht_taken;
    logic            btb_update;
    logic            btb_invalid;
    logic [XLEN-1:0] btb_pc;
    logic [XLEN-1:0] btb_target;

    modport master (
        output pred_push, pred_pc, pred_rvc, pred_kind, pred_taken, pred_target,
        output res_valid, res_taken, res_target, flush_ext,
        input  pred_full, predict_fail, redirect_pc,
        input  bht_updata, bht_pc, bht_taken,
        input  btb_update, btb_invalid, btb_pc, btb_target
    );

    modport slave (
        input  pred_push, pred_pc, pred_rvc, pred_kind, pred_taken, pred_target,
        input  res_valid, res_taken, res_target, flush_ext,
        output pred_full, predict_fail, redirect_pc,
        output bht_updata, bht_pc, bht_taken,
        output btb_update, btb_invalid, btb_pc, btb_target
    );

endinterface

// File: rtl/branch_resolve_fifo.sv
// pred_fifo: in-order circular queue of prediction records with push, pop, clear and head output.
module pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: record storage has no reset; count gates every read so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: checks the oldest fetch prediction against execute, raises flush/redirect and trains BHT/BTB.
// Optional statistics counters are enabled with `define BRANCH_RESOLVE_STATS_EN.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_if.slave      bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]          stat_resolved,
    output logic [31:0]          stat_mispredict
`endif
);
    localparam int REC_W = rec_bits(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            rvc;
        pred_kind_e      kind;
        logic            taken;
        logic [XLEN-1:0] target;
    } rec_t;

    rec_t            wr_rec;
    rec_t            head;
    logic [REC_W-1:0] head_bits;
    logic            empty;
    logic            accept;
    logic            clear;

    logic [XLEN-1:0] fallthrough;
    logic [XLEN-1:0] redirect;
    logic            fail;
    logic            bht_upd;
    logic            btb_upd;
    logic            btb_inv;

    assign wr_rec = '{
        pc:     bus.pred_pc,
        rvc:    bus.pred_rvc,
        kind:   bus.pred_kind,
        taken:  bus.pred_taken,
        target: bus.pred_target
    };

    assign accept = bus.res_valid && !empty;
    // A mispredict makes every younger record wrong-path, so the queue is dropped on the same edge.
    assign clear  = bus.flush_ext || (accept && fail);

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_pred_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.pred_push),
        .push_data (wr_rec),
        .pop       (accept),
        .clear     (clear),
        .full      (bus.pred_full),
        .empty     (empty),
        .head      (head_bits)
    );

    assign head        = rec_t'(head_bits);
    assign fallthrough = head.pc + (head.rvc ? XLEN'(2) : XLEN'(4));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fail     = 1'b0;
        redirect = fallthrough;
        bht_upd  = 1'b0;
        btb_upd  = 1'b0;
        btb_inv  = 1'b0;
        case (head.kind)
            KIND_BR: begin
                fail     = (bus.res_taken != head.taken) ||
                           (head.taken && bus.res_taken && (bus.res_target != head.target));
                redirect = bus.res_taken ? bus.res_target : fallthrough;
                bht_upd  = 1'b1;
            end
            KIND_JAL: begin
                fail     = !head.taken || (head.target != bus.res_target);
                redirect = bus.res_target;
            end
            KIND_JALR: begin
                fail     = !head.taken || (head.target != bus.res_target);
                redirect = bus.res_target;
                btb_upd  = fail;
            end
            default: begin
                // A taken prediction on a non-branch means the BTB entry aliased.
                fail     = head.taken;
                redirect = fallthrough;
                btb_inv  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.predict_fail <= 1'b0;
            bus.redirect_pc  <= '0;
            bus.bht_updata   <= 1'b0;
            bus.bht_pc       <= '0;
            bus.bht_taken    <= 1'b0;
            bus.btb_update   <= 1'b0;
            bus.btb_invalid  <= 1'b0;
            bus.btb_pc       <= '0;
            bus.btb_target   <= '0;
        end else begin
            bus.predict_fail <= 1'b0;
            bus.bht_updata   <= 1'b0;
            bus.btb_update   <= 1'b0;
            bus.btb_invalid  <= 1'b0;
            if (accept && !bus.flush_ext) begin
                bus.predict_fail <= fail;
                bus.redirect_pc  <= redirect;
                bus.bht_updata   <= bht_upd;
                bus.bht_pc       <= head.pc;
                bus.bht_taken    <= bus.res_taken;
                bus.btb_update   <= btb_upd;
                bus.btb_invalid  <= btb_inv;
                bus.btb_pc       <= head.pc;
                bus.btb_target   <= bus.res_target;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    // Saturating counters; an external flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else if (accept && !bus.flush_ext) begin
            if (stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
            if (fail && stat_mispredict != 32'hFFFF_FFFF) stat_mispredict <= stat_mispredict + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-side partner of the fetch-stage branch predictor.
- Records every prediction made at fetch in an in-order queue, then compares the oldest record against the actual outcome when the execute stage resolves it.
- Produces the mispredict flush with its redirect PC.
- Produces the BHT/BTB update strobes that train the predictor.

Parameters:
DEPTH, 4, number of in-flight prediction records (power of 2, >=2)
XLEN, 32, address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pred_push  in  1  fetch delivers one instruction together with its prediction record
pred_pc  in  XLEN  instruction PC
pred_rvc  in  1  instruction is 16-bit
pred_kind  in  2  pred_kind_e: KIND_NONE/KIND_BR/KIND_JAL/KIND_JALR
pred_taken  in  1  fetch predicted taken
pred_target  in  XLEN  fetch predicted target
pred_full  out  1  queue full; fetch must stall
res_valid  in  1  execute resolves the oldest record
res_taken  in  1  actual direction (ignored for KIND_NONE)
res_target  in  XLEN  actual target
flush_ext  in  1  trap/exception flush
predict_fail  out  1  mispredict pulse
redirect_pc  out  XLEN  correct next PC, valid with predict_fail
bht_updata  out  1  BHT train strobe
bht_pc  out  XLEN  BHT train PC
bht_taken  out  1  BHT train direction
btb_update  out  1  BTB write strobe
btb_invalid  out  1  BTB invalidate strobe
btb_pc  out  XLEN  BTB entry PC
btb_target  out  XLEN  BTB write target

Behaviour:
- Reset: queue empty; pred_full=0; all strobes 0; redirect_pc, bht_pc, btb_pc, btb_target = 0.
- Queue is circular with wrapping read and write pointers and a count of width clog2(DEPTH)+1.
- A push while full is dropped; fetch must honour pred_full.
- res_valid while empty is ignored. Bench asserts it never happens.
- Push and pop in the same cycle are allowed when full; count stays unchanged.
- Fallthrough = pred_pc + (pred_rvc ? 2 : 4), computed modulo 2^XLEN.
- Evaluation of the head record on res_valid:
  - KIND_BR:
    - Fail if res_taken != pred_taken, or if both are taken and res_target != pred_target.
    - Redirect = res_taken ? res_target : fallthrough.
    - Always pulse bht_updata with bht_taken=res_taken.
  - KIND_JAL: fail if !pred_taken or pred_target != res_target; redirect = res_target. No table update.
  - KIND_JALR:
    - Fail if !pred_taken or pred_target != res_target; redirect = res_target.
    - On fail, pulse btb_update with btb_target=res_target.
  - KIND_NONE: fail if pred_taken (aliased BTB hit); redirect = fallthrough; pulse btb_invalid.
- Latency: all outputs are registered one-cycle pulses, visible the cycle after res_valid.
- On fail, the queue is cleared in the same edge, because all younger records are wrong-path. A pred_push in that cycle is discarded.
- flush_ext clears the queue and suppresses all outputs for that cycle. It takes priority over a simultaneous res_valid, push, or fail.
- Reset asserted mid-operation behaves like a full reset; pending pulses are dropped.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined:
  - Adds 32-bit output ports stat_resolved and stat_mispredict, reset to 0.
  - stat_resolved increments on each accepted res_valid; stat_mispredict increments on each predict_fail.
  - Both counters saturate at 32'hFFFF_FFFF and are not cleared by flush_ext.
- Undefined: the ports and counters are absent.

Decomposition:
- riscv_pkg gains pred_kind_e (2-bit enum) and the pred_rec_t packed struct {pc, rvc, kind, taken, target}.
- Sub-module pred_fifo: parameterised DEPTH circular queue with push/pop/clear, full/empty, and a head-record output.
- branch_resolve holds the compare, redirect, and update logic and the output registers.

Test Plan:
1. Push BR pc=0x100, rvc=0, taken=0; resolve res_taken=1, target=0x140.
   -> next cycle predict_fail=1, redirect_pc=0x140, bht_updata=1, bht_pc=0x100, bht_taken=1.
2. Push BR pc=0x200, rvc=1, taken=1, target=0x180; resolve res_taken=0.
   -> predict_fail=1, redirect_pc=0x202, bht_taken=0.
3. Push JALR pc=0x300, taken=1, target=0x400; resolve target=0x500.
   -> predict_fail=1, redirect_pc=0x500, btb_update=1, btb_pc=0x300, btb_target=0x500.
4. Push DEPTH=4 NONE records (pred_taken=0) -> pred_full=1. Push a 5th -> dropped.
   Then a simultaneous push and resolve -> count stays 4, no predict_fail.
5. With 3 records queued, mispredict the head -> queue empty next cycle (pred_full=0). A subsequent res_valid produces no output.
6. Assert flush_ext in the same cycle as res_valid on a mispredicting head -> no predict_fail, no strobes, queue empty.
